// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and default parameter values for the round-robin bus arbiter.
package bus_rr_arbiter_pkg;

  // The arbiter either has no owner (IDLE) or is serving one initiator (OWN)
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_BURST  = 16;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first requester strictly after
// the previous owner, wrapping around, and reports it one-hot and as an index.
module rr_pick
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_lastOwner,
  output logic [NUM_REQ-1:0]         o_oneHot,
  output logic [$clog2(NUM_REQ)-1:0] o_index
);

  localparam int IDW = $clog2(NUM_REQ);

  logic           w_found;
  logic [IDW-1:0] w_candIdx;

  // Walk the requesters starting one past the last owner; the first hit wins
  always_comb begin
    o_oneHot  = '0;
    o_index   = '0;
    w_found   = 1'b0;
    w_candIdx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_candIdx = IDW'((int'(i_lastOwner) + k) % NUM_REQ);
      if (!w_found && i_req[w_candIdx]) begin
        w_found             = 1'b1;
        o_index             = w_candIdx;
        o_oneHot[w_candIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one responder bus among NUM_REQ initiators.
// An owner keeps the bus until it sends a last beat or hits MAX_BURST beats.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          bus_valid,
  output logic                          bus_last,
  output logic [DATA_WIDTH-1:0]         bus_data,
  input  logic                          bus_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          burst_abort
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [IDW-1:0]       r_owner;
  logic [NUM_REQ-1:0]   r_ownerOneHot;
  logic [IDW-1:0]       r_lastOwner;
  logic [CW-1:0]        r_count;
  logic                 r_abort;

  logic [NUM_REQ-1:0]   w_pickOneHot;
  logic [IDW-1:0]       w_pickIndex;
  logic                 w_accept;
  logic                 w_release;
  logic [CW-1:0]        w_countInc;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req       (req_valid),
    .i_lastOwner (r_lastOwner),
    .o_oneHot    (w_pickOneHot),
    .o_index     (w_pickIndex)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus the combinational bus mux; the owner's beat passes straight through
  always_comb begin
    w_nextState = r_state;
    req_ready   = '0;
    bus_valid   = 1'b0;
    bus_last    = 1'b0;
    bus_data    = '0;
    grant       = '0;
    grant_id    = '0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_countInc  = r_count + CW'(1);
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_nextState = OWN;
        end
      end
      OWN: begin
        grant              = r_ownerOneHot;
        grant_id           = r_owner;
        bus_valid          = req_valid[r_owner];
        bus_last           = req_last[r_owner];
        bus_data           = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
        req_ready[r_owner] = bus_ready;
        w_accept           = req_valid[r_owner] && bus_ready;
        w_release          = w_accept && (req_last[r_owner] || (w_countInc == CW'(MAX_BURST)));
        if (w_release) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Owner capture, beat counting and the one-cycle abort pulse on forced release
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner       <= '0;
      r_ownerOneHot <= '0;
      r_lastOwner   <= IDW'(NUM_REQ - 1);
      r_count       <= '0;
      r_abort       <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (r_state == IDLE) begin
        r_count <= '0;
        if (|req_valid) begin
          r_owner       <= w_pickIndex;
          r_ownerOneHot <= w_pickOneHot;
        end
      end else if (w_release) begin
        r_lastOwner <= r_owner;
        r_count     <= '0;
        r_abort     <= !req_last[r_owner];
      end else if (w_accept) begin
        r_count <= w_countInc;
      end
    end
  end

  assign burst_abort = r_abort;

endmodule
